// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot blocks
// (sensor decoder, occupancy controller, display).
package parking_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} gate_state_t;

  localparam int DEFAULT_CAPACITY = 16;
  localparam int DEFAULT_TIMEOUT  = 50;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that stops at zero. The done output is high
// whenever the count has run out.
module gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/parking_lot_controller.sv
// Occupancy counter with sticky over/underflow flags, plus the entry-gate
// sequencer that grants a ticket request only while a space is free.
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter  int CAPACITY = DEFAULT_CAPACITY,
  parameter  int TIMEOUT  = DEFAULT_TIMEOUT,
  localparam int CW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter,
  input  logic          exit,
  input  logic          entry_req,
  input  logic          clear_err,
  output logic          gate_open,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CAP   = CW'(CAPACITY);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          incOnly;
  logic          decOnly;
  logic          ovfEvent;
  logic          unfEvent;

  gate_state_t   state_q;
  gate_state_t   state_d;
  logic          gateOpen_q;
  logic          timerLoad;
  logic          timerDone;

  assign incOnly  = enter & ~exit;
  assign decOnly  = exit & ~enter;
  assign ovfEvent = incOnly & (count_q == CAP);
  assign unfEvent = decOnly & (count_q == '0);

  // A new error event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (incOnly && !ovfEvent) begin
        count_q <= count_q + CW'(1);
      end else if (decOnly && !unfEvent) begin
        count_q <= count_q - CW'(1);
      end
      overflow_q  <= (overflow_q & ~clear_err) | ovfEvent;
      underflow_q <= (underflow_q & ~clear_err) | unfEvent;
    end
  end

  assign count         = count_q;
  assign full          = (count_q == CAP);
  assign empty         = (count_q == '0);
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  gate_timer #(
    .W(TW)
  ) u_gate_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .load_value(TLOAD),
    .done      (timerDone)
  );

  // The timer is loaded on the grant edge so it reads TIMEOUT-1 in the first OPEN cycle.
  always_comb begin
    state_d   = state_q;
    timerLoad = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_req && !full) begin
          state_d   = OPEN;
          timerLoad = 1'b1;
        end
      end
      OPEN: begin
        if (enter || timerDone) begin
          state_d = CLOSE;
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gateOpen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gateOpen_q <= (state_d == OPEN);
    end
  end

  assign gate_open = gateOpen_q;

endmodule
